// File: rtl/capture_strobe_arbiter.sv
// Arbitrates N_REQ capture requesters onto one shared capture register using a single-clock strobe.
// Optional macro CAP_STATS_EN adds an 8-bit saturating count of completed captures on cap_cnt.
module capture_strobe_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DW       = 1,
    parameter int HOLD_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DW-1:0]   din,
    input  logic [1:0]            mode,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      ack,
    output logic                  cap_en,
    output logic [DW-1:0]         q,
    output logic                  busy,
    output logic [7:0]            cap_cnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC);
    localparam logic [PW-1:0] LAST_IDX  = PW'(N_REQ - 1);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t            r_state, w_state_next;
    logic [N_REQ-1:0]  r_gnt, w_gnt_next;
    logic [PW-1:0]     r_win, w_win_next;
    logic [PW-1:0]     r_rr_ptr, w_rr_ptr_next;
    logic [HW-1:0]     r_hold_cnt, w_hold_cnt_next;
    logic [DW-1:0]     r_q, w_q_next;
    logic [N_REQ-1:0]  w_low_mask;
    logic [N_REQ-1:0]  w_eligible;
    logic [PW-1:0]     w_pick;
    logic              w_capture;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_low_mask
            assign w_low_mask[gi] = (gi < N_REQ / 2);
        end
    endgenerate

    always_comb begin
        case (mode)
            2'b10:   w_eligible = req & w_low_mask;
            2'b11:   w_eligible = '0;
            default: w_eligible = req;
        endcase
    end

    // Scan downwards so the last hit written is the first one in search order.
    always_comb begin
        int t;
        t      = 0;
        w_pick = '0;
        if (mode == 2'b00) begin
            for (int off = N_REQ - 1; off >= 0; off--) begin
                t = int'(r_rr_ptr) + off;
                if (t >= N_REQ) t = t - N_REQ;
                if (w_eligible[t]) w_pick = PW'(t);
            end
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                if (w_eligible[k]) w_pick = PW'(k);
            end
        end
    end

    // A capture needs the winner still requesting on the final hold cycle.
    assign w_capture = (r_state == S_GRANT) && (r_hold_cnt == HOLD_LAST) && req[r_win];

    always_comb begin
        w_state_next    = r_state;
        w_gnt_next      = r_gnt;
        w_win_next      = r_win;
        w_rr_ptr_next   = r_rr_ptr;
        w_hold_cnt_next = r_hold_cnt;
        w_q_next        = r_q;
        case (r_state)
            S_IDLE: begin
                if (|w_eligible) begin
                    w_gnt_next      = N_REQ'(1) << w_pick;
                    w_win_next      = w_pick;
                    w_hold_cnt_next = HW'(1);
                    w_state_next    = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!req[r_win]) begin
                    w_gnt_next      = '0;
                    w_hold_cnt_next = '0;
                    w_state_next    = S_IDLE;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_q_next        = din[r_win*DW +: DW];
                    w_rr_ptr_next   = (r_win == LAST_IDX) ? '0 : r_win + 1'b1;
                    w_gnt_next      = '0;
                    w_hold_cnt_next = '0;
                    w_state_next    = S_IDLE;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_win      <= '0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_q        <= '0;
        end else begin
            r_state    <= w_state_next;
            r_gnt      <= w_gnt_next;
            r_win      <= w_win_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_q        <= w_q_next;
        end
    end

    assign gnt    = r_gnt;
    assign ack    = w_capture ? r_gnt : '0;
    assign cap_en = w_capture;
    assign q      = r_q;
    assign busy   = (r_state == S_GRANT);

`ifdef CAP_STATS_EN
    logic [7:0] r_cap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_cnt <= 8'h00;
        end else if (w_capture && (r_cap_cnt != 8'hFF)) begin
            r_cap_cnt <= r_cap_cnt + 8'h01;
        end
    end

    assign cap_cnt = r_cap_cnt;
`else
    assign cap_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_capture_strobe_arbiter.sv
// Scoreboard bench for capture_strobe_arbiter: stimulus queues expected captures, a monitor checks them.
module tb_capture_strobe_arbiter;

    localparam int N    = 4;
    localparam int DW   = 4;
    localparam int HOLD = 2;
`ifdef CAP_STATS_EN
    localparam int SAT_EXP = 255;
    localparam int MID_EXP = 10;
`else
    localparam int SAT_EXP = 0;
    localparam int MID_EXP = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*DW-1:0]   din = {4'd3, 4'd2, 4'd1, 4'd0};
    logic [1:0]        mode = 2'b00;
    logic [N-1:0]      gnt;
    logic [N-1:0]      ack;
    logic              cap_en;
    logic [DW-1:0]     q;
    logic              busy;
    logic [7:0]        cap_cnt;

    capture_strobe_arbiter #(.N_REQ(N), .DW(DW), .HOLD_CYC(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din), .mode(mode),
        .gnt(gnt), .ack(ack), .cap_en(cap_en), .q(q), .busy(busy), .cap_cnt(cap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  ack;
        logic [DW-1:0] q;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [N-1:0] a, input logic [DW-1:0] d, input int times);
        exp_t e;
        e.ack = a;
        e.q   = d;
        for (int i = 0; i < times; i++) exp_q.push_back(e);
    endtask

    // Monitor: each cap_en pops one expected capture; q is checked the following cycle.
    int            cyc = 0;
    int            rise_cyc = 0;
    logic [N-1:0]  prev_gnt = '0;
    logic          q_pending = 1'b0;
    logic [DW-1:0] q_exp = '0;

    always @(negedge clk) begin
        exp_t e;
        if (q_pending) begin
            chk("q_after_capture", q, q_exp);
            q_pending = 1'b0;
        end
        if (gnt != '0 && prev_gnt == '0) rise_cyc = cyc;
        if (cap_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_cap_en", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("ack", ack, e.ack);
                chk("gnt_at_capture", gnt, e.ack);
                chk("cap_delay", cyc - rise_cyc, HOLD - 1);
                $display("capture: ack=%b q_next=%0d", ack, e.q);
                q_pending = 1'b1;
                q_exp     = e.q;
            end
        end
        prev_gnt = gnt;
        cyc++;
    end

    // Counts cap_en pulses, then returns one time step after the capturing edge.
    task automatic wait_caps(input int n, input string name);
        int seen = 0;
        int budget = 0;
        while (seen < n && budget < 20 * n + 20) begin
            @(negedge clk);
            if (cap_en) seen++;
            budget++;
        end
        if (seen < n) chk({name, "_timeout"}, seen, n);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string name);
        int budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (gnt == '0 && budget < 20);
        if (gnt == '0) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic watch_idle(input int cycles, output logic seen_gnt, output logic seen_busy);
        seen_gnt  = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (gnt != '0) seen_gnt = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
    endtask

    logic sg, sb;

    initial begin
        #12;
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_cap_en", cap_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_q", q, 0);
        chk("rst_cap_cnt", cap_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin over all four requesters, wrapping back to 0.
        mode = 2'b00;
        push_exp(4'b0001, 4'd0, 1);
        push_exp(4'b0010, 4'd1, 1);
        push_exp(4'b0100, 4'd2, 1);
        push_exp(4'b1000, 4'd3, 1);
        push_exp(4'b0001, 4'd0, 1);
        @(negedge clk);
        req = 4'b1111;
        wait_caps(5, "rr");
        req = 4'b0000;
        $display("round-robin sequence done");

        // Fixed priority: index 1 always beats index 3.
        @(negedge clk);
        mode = 2'b01;
        push_exp(4'b0010, 4'd1, 3);
        req = 4'b1010;
        wait_caps(3, "prio");
        req = 4'b0000;
        $display("fixed priority done");

        // Low-half mode ignores upper requesters; disabled mode grants nothing.
        @(negedge clk);
        mode = 2'b10;
        req  = 4'b1100;
        watch_idle(10, sg, sb);
        chk("mode10_no_gnt", sg, 0);
        mode = 2'b11;
        req  = 4'b1111;
        watch_idle(10, sg, sb);
        chk("mode11_no_gnt", sg, 0);
        chk("mode11_no_busy", sb, 0);
        req = 4'b0000;
        $display("masked modes done");

        // Abort in grant cycle 1: rr_ptr is 2, so index 2 wins and is re-granted later.
        @(negedge clk);
        mode = 2'b00;
        req  = 4'b1111;
        wait_gnt("abort_gnt");
        chk("abort_winner", gnt, 4'b0100);
        req = 4'b0000;
        watch_idle(4, sg, sb);
        chk("abort_gnt_drops", sg, 0);
        chk("abort_q_unchanged", q, 4'd1);
        push_exp(4'b0100, 4'd2, 1);
        req = 4'b1111;
        wait_caps(1, "regrant");
        req = 4'b0000;
        $display("abort and re-grant done");

        // Mode switch to disabled mid-grant: capture of index 3 still completes.
        @(negedge clk);
        push_exp(4'b1000, 4'd3, 1);
        req = 4'b1111;
        wait_gnt("modesw_gnt");
        mode = 2'b11;
        wait_caps(1, "modesw");
        watch_idle(10, sg, sb);
        chk("modesw_no_more_gnt", sg, 0);
        req = 4'b0000;
        $display("mode switch mid-grant done");

        // Asynchronous reset mid-grant clears everything without a strobe.
        @(negedge clk);
        mode = 2'b00;
        req  = 4'b1111;
        wait_gnt("rst_mid_gnt");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", gnt, 0);
        chk("midrst_ack", ack, 0);
        chk("midrst_cap_en", cap_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_q", q, 0);
        chk("midrst_cap_cnt", cap_cnt, 0);
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset mid-grant done");

        // Capture counter: 10 then 300 captures (saturates at 255 when enabled).
        @(negedge clk);
        mode = 2'b01;
        push_exp(4'b0001, 4'd0, 300);
        req = 4'b0001;
        wait_caps(10, "cnt10");
        chk("cap_cnt_10", cap_cnt, MID_EXP);
        wait_caps(290, "cnt300");
        req = 4'b0000;
        chk("cap_cnt_sat", cap_cnt, SAT_EXP);
        $display("capture counter done");

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
